// File: rtl/ram_pkg.sv
// Shared defaults for the single-port register-file RAM.
// Word width and address width used by ram unless overridden at instantiation.
package ram_pkg;

    localparam int RAM_DATA_W = 8;
    localparam int RAM_ADDR_W = 4;

endpackage

// File: rtl/ram.sv
// Single-port RAM, 2**ADDR_W words of DATA_W bits, read-before-write on a shared address.
// Latency: registered read, data_out valid one edge after rd/addr are sampled.
// Backpressure: none; accepts a read and/or write every cycle with no stall.
module ram
    import ram_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              wr,
    input  logic              rd,
    output logic [DATA_W-1:0] data_out
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Reset clears every word in one edge, so storage stays in flops, not a macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            data_out <= '0;
        end else begin
            if (rd) begin
                data_out <= mem[addr];
            end
            if (wr) begin
                mem[addr] <= data_in;
            end
        end
    end

endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram: directed vector table followed by randomized traffic
// compared against an array-based reference model.
module tb_ram;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic          wr;
    logic          rd;
    logic [DW-1:0] data_out;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: memory array plus the last read word.
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_out;

    typedef struct {
        string         name;
        logic          rst;
        logic          wr;
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    ram #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .wr       (wr),
        .rd       (rd),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic add_vec(input string name, input logic r, input logic w, input logic rdv,
                           input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] e);
        vec_t v;
        v.name = name; v.rst = r; v.wr = w; v.rd = rdv; v.addr = a; v.din = d; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: data_out=%h expected=%h", name, act, exp);
    endtask

    // Drive one cycle, let the edge happen, then advance the reference model.
    task automatic step(input logic r, input logic w, input logic rdv,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        rst = r; wr = w; rd = rdv; addr = a; data_in = d;
        @(posedge clk);
        #1;
        if (r) begin
            foreach (ref_mem[i]) ref_mem[i] = '0;
            ref_out = '0;
        end else begin
            if (rdv) ref_out = ref_mem[a];
            if (w) ref_mem[a] = d;
        end
    endtask

    initial begin
        logic [DW-1:0] wvals [5];
        wvals[0] = 8'hFF; wvals[1] = 8'hFE; wvals[2] = 8'hFC; wvals[3] = 8'hF8; wvals[4] = 8'hF0;

        rst = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; data_in = '0;
        foreach (ref_mem[i]) ref_mem[i] = 'x;
        ref_out = 'x;

        add_vec("reset", 1, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < DEPTH; i++) add_vec("reset_read", 0, 0, 1, AW'(i), 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) add_vec("write_hold", 0, 1, 0, AW'(i), wvals[i], 8'h00);
        for (int i = 0; i < 5; i++) add_vec("readback", 0, 0, 1, AW'(i), 8'h00, wvals[i]);
        add_vec("hold_rd0", 0, 0, 0, 0, 8'h33, 8'hF0);
        add_vec("rbw_old", 0, 1, 1, 2, 8'h5A, 8'hFC);
        add_vec("rbw_new", 0, 0, 1, 2, 8'h00, 8'h5A);
        add_vec("rst_prio", 1, 1, 1, 3, 8'h77, 8'h00);
        add_vec("rst_prio_read", 0, 0, 1, 3, 8'h00, 8'h00);
        add_vec("rst_clr_other", 0, 0, 1, 0, 8'h00, 8'h00);
        add_vec("bnd_wr15", 0, 1, 0, 15, 8'hAA, 8'h00);
        add_vec("bnd_wr0", 0, 1, 0, 0, 8'h55, 8'h00);
        add_vec("bnd_rd15", 0, 0, 1, 15, 8'h00, 8'hAA);
        add_vec("bnd_rd0", 0, 0, 1, 0, 8'h00, 8'h55);
        add_vec("wr0_noeffect", 0, 0, 0, 15, 8'h11, 8'h55);
        add_vec("wr0_reread", 0, 0, 1, 15, 8'h22, 8'hAA);

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].din);
            check(vecs[i].name, data_out, vecs[i].exp);
        end

        // Back-to-back reads every cycle with no gap cycle.
        step(0, 1, 0, 7, 8'hC3);
        step(0, 1, 0, 8, 8'h3C);
        step(0, 0, 1, 7, 8'h00);
        check("b2b_rd7", data_out, 8'hC3);
        step(0, 0, 1, 8, 8'h00);
        check("b2b_rd8", data_out, 8'h3C);

        // Randomized traffic against the model; occasional reset.
        for (int i = 0; i < 400; i++) begin
            logic r;
            r = ($urandom_range(0, 40) == 0);
            step(r, 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
            check(r ? "rand_rst" : "rand", data_out, ref_out);
        end

        // Sweep every address to confirm the final memory image.
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 1, AW'(i), 8'h00);
            check("final_sweep", data_out, ref_out);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: run exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
